// File: rtl/jtpopeye_dma_if.sv
// Bus bundle between the object-RAM DMA engine and its surroundings:
// Z80 bus handshake, main RAM read port and object buffer write port.
interface jtpopeye_dma_if;
  logic       cpu_cen;
  logic       VB;
  logic       dma_en;
  logic       busrq_n;
  logic       busak_n;
  logic       dma_cs;
  logic [9:0] AD_DMA;
  logic [7:0] DD_DMA;
  logic [9:0] obj_addr;
  logic [7:0] obj_data;
  logic       obj_we;
  logic       busy;
  logic       done;

  modport master (
    input  cpu_cen, VB, dma_en, busak_n, DD_DMA,
    output busrq_n, dma_cs, AD_DMA, obj_addr, obj_data, obj_we, busy, done
  );

  modport slave (
    output cpu_cen, VB, dma_en, busak_n, DD_DMA,
    input  busrq_n, dma_cs, AD_DMA, obj_addr, obj_data, obj_we, busy, done
  );
endinterface

// File: rtl/jtpopeye_dma.sv
// Object-RAM DMA: on each enabled VB rising edge, borrow the Z80 bus and copy
// DMA_LEN bytes from the upper main-RAM half into the object buffer.
module jtpopeye_dma #(
  parameter logic [9:0]  DMA_START   = 10'h000,
  parameter logic [10:0] DMA_LEN     = 11'd1024,
  parameter logic [7:0]  ACK_TIMEOUT = 8'd255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  jtpopeye_dma_if.master        dma_bus
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_XFER  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  state_t      r_state;
  logic        r_vbl;
  logic        r_busrq_n;
  logic        r_dma_cs;
  logic [9:0]  r_ad;
  logic [9:0]  r_obj_addr;
  logic [7:0]  r_obj_data;
  logic        r_obj_we;
  logic        r_busy;
  logic        r_done;
  logic        r_first;
  logic [7:0]  r_tmo;
  logic [10:0] r_iss;
  logic [9:0]  r_bcnt;

  logic        w_trig;
  logic        w_ack;

  assign w_trig = dma_bus.VB & ~r_vbl;
  assign w_ack  = ~dma_bus.busak_n;

  assign dma_bus.busrq_n  = r_busrq_n;
  assign dma_bus.dma_cs   = r_dma_cs;
  assign dma_bus.AD_DMA   = r_ad;
  assign dma_bus.obj_addr = r_obj_addr;
  assign dma_bus.obj_data = r_obj_data;
  assign dma_bus.obj_we   = r_obj_we;
  assign dma_bus.busy     = r_busy;
  assign dma_bus.done     = r_done;

  // Transfer sequencer; RAM data lags its address by one cen tick, so writes trail by one tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_vbl      <= 1'b0;
      r_busrq_n  <= 1'b1;
      r_dma_cs   <= 1'b0;
      r_ad       <= DMA_START;
      r_obj_addr <= 10'd0;
      r_obj_data <= 8'd0;
      r_obj_we   <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_first    <= 1'b0;
      r_tmo      <= 8'd0;
      r_iss      <= 11'd0;
      r_bcnt     <= 10'd0;
    end else begin
      r_obj_we <= 1'b0;
      r_done   <= 1'b0;
      if (dma_bus.cpu_cen) begin
        r_vbl <= dma_bus.VB;
        case (r_state)
          ST_IDLE: begin
            if (w_trig && dma_bus.dma_en) begin
              r_state   <= ST_REQ;
              r_busrq_n <= 1'b0;
              r_busy    <= 1'b1;
              r_tmo     <= 8'd0;
            end else begin
              r_state <= ST_IDLE;
            end
          end
          ST_REQ: begin
            if (w_ack) begin
              r_state  <= ST_XFER;
              r_dma_cs <= 1'b1;
              r_ad     <= DMA_START;
              r_iss    <= 11'd1;
              r_bcnt   <= 10'd0;
              r_first  <= 1'b1;
            end else if (r_tmo == ACK_TIMEOUT - 8'd1) begin
              r_state   <= ST_IDLE;
              r_busrq_n <= 1'b1;
              r_busy    <= 1'b0;
            end else begin
              r_tmo <= r_tmo + 8'd1;
            end
          end
          ST_XFER: begin
            if (!w_ack) begin
              // CPU took the bus back: drop everything, keep what was written
              r_state   <= ST_IDLE;
              r_dma_cs  <= 1'b0;
              r_busrq_n <= 1'b1;
              r_busy    <= 1'b0;
            end else begin
              r_ad    <= r_ad + 10'd1;
              r_first <= 1'b0;
              if (!r_first) begin
                r_obj_we   <= 1'b1;
                r_obj_data <= dma_bus.DD_DMA;
                r_obj_addr <= r_bcnt;
                r_bcnt     <= r_bcnt + 10'd1;
              end else begin
                r_bcnt <= r_bcnt;
              end
              if (r_iss == DMA_LEN) begin
                r_state <= ST_DRAIN;
              end else begin
                r_iss <= r_iss + 11'd1;
              end
            end
          end
          ST_DRAIN: begin
            if (!w_ack) begin
              r_state   <= ST_IDLE;
              r_dma_cs  <= 1'b0;
              r_busrq_n <= 1'b1;
              r_busy    <= 1'b0;
            end else begin
              r_obj_we   <= 1'b1;
              r_obj_data <= dma_bus.DD_DMA;
              r_obj_addr <= r_bcnt;
              r_bcnt     <= r_bcnt + 10'd1;
              r_dma_cs   <= 1'b0;
              r_state    <= ST_DONE;
            end
          end
          ST_DONE: begin
            r_busrq_n <= 1'b1;
            r_busy    <= 1'b0;
            r_done    <= 1'b1;
            r_state   <= ST_IDLE;
          end
          default: begin
            r_state   <= ST_IDLE;
            r_dma_cs  <= 1'b0;
            r_busrq_n <= 1'b1;
            r_busy    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_jtpopeye_dma.sv
// Scoreboard bench for jtpopeye_dma: RAM and Z80 bus models around one DUT,
// expected object-buffer writes queued per frame and popped as obj_we fires.
module tb_jtpopeye_dma;
  localparam logic [9:0]  START = 10'h3FE;
  localparam logic [10:0] LEN   = 11'd5;
  localparam logic [7:0]  TMO   = 8'd12;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  jtpopeye_dma_if bus();

  jtpopeye_dma #(.DMA_START(START), .DMA_LEN(LEN), .ACK_TIMEOUT(TMO)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .dma_bus (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;

  // cpu_cen every other clk, freezable
  logic cen_ph   = 1'b0;
  logic cen_hold = 1'b0;
  always @(posedge clk) cen_ph <= ~cen_ph;
  assign bus.cpu_cen = cen_ph & ~cen_hold;

  int tick = 0;
  always @(posedge clk) if (bus.cpu_cen) tick <= tick + 1;

  // main RAM upper half, one cen tick read latency
  logic [7:0] mem [0:1023];
  logic [7:0] dd_r = 8'h00;
  always @(posedge clk) if (bus.cpu_cen) dd_r <= mem[bus.AD_DMA];
  assign bus.DD_DMA = dd_r;

  // Z80 bus acknowledge model
  int   ack_dly   = 1;
  int   ack_cnt   = 0;
  logic ack_n_r   = 1'b1;
  logic ack_block = 1'b0;
  int   abort_at  = 0;
  int   wr_cnt    = 0;
  always @(posedge clk) begin
    if (bus.cpu_cen) begin
      if (bus.busrq_n) begin
        ack_cnt <= 0;
        ack_n_r <= 1'b1;
      end else if (ack_cnt >= ack_dly) begin
        ack_n_r <= 1'b0;
      end else begin
        ack_cnt <= ack_cnt + 1;
      end
    end
  end
  assign bus.busak_n = ack_n_r | ack_block | (abort_at != 0 && wr_cnt >= abort_at);

  logic [17:0] exp_q [$];
  int done_cnt = 0, rq_cnt = 0;
  int rq_fall_t = 0, rq_rise_t = 0, cs_rise_t = 0, cs_fall_t = 0, busy_rise_t = 0, wr_t = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic push_frame(input int n);
    logic [9:0] a;
    for (int k = 0; k < n; k++) begin
      a = START + 10'(k);
      exp_q.push_back({10'(k), mem[a]});
    end
  endtask

  task automatic monitor();
    logic        p_rq = 1'b1, p_cs = 1'b0, p_busy = 1'b0;
    logic [17:0] e;
    forever begin
      @(negedge clk);
      if (p_rq && !bus.busrq_n) begin rq_cnt++; rq_fall_t = tick; end
      if (!p_rq && bus.busrq_n) rq_rise_t = tick;
      if (!p_cs && bus.dma_cs) cs_rise_t = tick;
      if (p_cs && !bus.dma_cs) cs_fall_t = tick;
      if (!p_busy && bus.busy) busy_rise_t = tick;
      if (bus.obj_we) begin
        wr_cnt++;
        wr_t = tick;
        if (exp_q.size() == 0) begin
          chk("unexpected_we", 32'(bus.obj_addr), 32'h0000FFFF);
        end else begin
          e = exp_q.pop_front();
          chk("obj_addr", 32'(bus.obj_addr), 32'(e[17:8]));
          chk("obj_data", 32'(bus.obj_data), 32'(e[7:0]));
        end
      end
      if (bus.done) done_cnt++;
      p_rq   = bus.busrq_n;
      p_cs   = bus.dma_cs;
      p_busy = bus.busy;
    end
  endtask

  task automatic vb_pulse();
    @(negedge clk);
    bus.VB = 1'b1;
    repeat (6) @(negedge clk);
    bus.VB = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int bound);
    int n = 0;
    while (bus.busy && n < bound) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(bus.busy), 32'd0);
  endtask

  task automatic settle();
    repeat (3) @(negedge clk);
    #1;
  endtask

  int w0, d0, r0, w, n;

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 8'(i * 37 + 5);
    mem[10'h3FE] = 8'h11; mem[10'h3FF] = 8'h22; mem[10'h000] = 8'h33;
    mem[10'h001] = 8'h44; mem[10'h002] = 8'h55;
    bus.VB = 1'b0;
    bus.dma_en = 1'b1;
    fork monitor(); join_none

    // reset values, asynchronously
    #2 rst_n = 1'b0;
    #1;
    chk("rst_busrq_n", 32'(bus.busrq_n), 32'd1);
    chk("rst_dma_cs", 32'(bus.dma_cs), 32'd0);
    chk("rst_ad", 32'(bus.AD_DMA), 32'(START));
    chk("rst_obj_addr", 32'(bus.obj_addr), 32'd0);
    chk("rst_obj_data", 32'(bus.obj_data), 32'd0);
    chk("rst_obj_we", 32'(bus.obj_we), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // normal wrapped transfer
    push_frame(int'(LEN));
    w0 = wr_cnt; d0 = done_cnt;
    vb_pulse();
    wait_idle("t1_idle", 200);
    settle();
    chk("t1_writes", wr_cnt - w0, int'(LEN));
    chk("t1_done", done_cnt - d0, 1);
    chk("t1_ack_to_rel", rq_rise_t - cs_rise_t, int'(LEN) + 2);
    chk("t1_busy_with_rq", busy_rise_t, rq_fall_t);
    chk("t1_q_empty", exp_q.size(), 0);
    chk("t1_cs_low", 32'(bus.dma_cs), 32'd0);

    // no acknowledge: request abandoned after ACK_TIMEOUT ticks
    ack_block = 1'b1;
    w0 = wr_cnt; d0 = done_cnt;
    vb_pulse();
    wait_idle("t2_idle", 200);
    settle();
    chk("t2_timeout", rq_rise_t - rq_fall_t, int'(TMO));
    chk("t2_writes", wr_cnt - w0, 0);
    chk("t2_done", done_cnt - d0, 0);
    chk("t2_busrq_n", 32'(bus.busrq_n), 32'd1);
    ack_block = 1'b0;

    // bus stolen back after the 2nd write
    push_frame(2);
    w0 = wr_cnt; d0 = done_cnt;
    abort_at = wr_cnt + 2;
    vb_pulse();
    wait_idle("t3_idle", 200);
    settle();
    chk("t3_writes", wr_cnt - w0, 2);
    chk("t3_done", done_cnt - d0, 0);
    chk("t3_cs_fall", cs_fall_t, wr_t + 1);
    chk("t3_q_empty", exp_q.size(), 0);
    abort_at = 0;
    push_frame(int'(LEN));
    w0 = wr_cnt; d0 = done_cnt;
    vb_pulse();
    wait_idle("t3b_idle", 200);
    settle();
    chk("t3b_writes", wr_cnt - w0, int'(LEN));
    chk("t3b_done", done_cnt - d0, 1);
    chk("t3b_q_empty", exp_q.size(), 0);

    // second VB edge mid-transfer, cen freeze, dma_en dropped mid-transfer
    push_frame(int'(LEN));
    ack_dly = 3;
    w0 = wr_cnt; d0 = done_cnt; r0 = rq_cnt;
    @(negedge clk);
    bus.VB = 1'b1;
    n = 0;
    while (!bus.dma_cs && n < 100) begin @(negedge clk); n++; end
    chk("t4_cs_up", 32'(bus.dma_cs), 32'd1);
    bus.VB = 1'b0;
    repeat (4) @(negedge clk);
    bus.VB = 1'b1;
    bus.dma_en = 1'b0;
    cen_hold = 1'b1;
    @(negedge clk);
    #1 w = wr_cnt;
    repeat (10) @(negedge clk);
    #1;
    chk("t4_hold_frozen", wr_cnt, w);
    chk("t4_hold_cs", 32'(bus.dma_cs), 32'd1);
    cen_hold = 1'b0;
    wait_idle("t4_idle", 200);
    bus.dma_en = 1'b1;
    repeat (20) @(negedge clk);
    bus.VB = 1'b0;
    settle();
    chk("t4_one_request", rq_cnt - r0, 1);
    chk("t4_writes", wr_cnt - w0, int'(LEN));
    chk("t4_done", done_cnt - d0, 1);
    chk("t4_q_empty", exp_q.size(), 0);

    bus.dma_en = 1'b0;
    r0 = rq_cnt;
    vb_pulse();
    repeat (20) @(negedge clk);
    settle();
    chk("t5_dis_no_rq", rq_cnt - r0, 0);
    chk("t5_dis_busy", 32'(bus.busy), 32'd0);
    bus.dma_en = 1'b1;
    ack_dly = 1;

    // asynchronous reset while a write strobe is high
    push_frame(int'(LEN));
    w0 = wr_cnt;
    @(negedge clk);
    bus.VB = 1'b1;
    n = 0;
    do begin @(negedge clk); #1; n++; end while (wr_cnt == w0 && n < 100);
    chk("t6_we_seen", 32'(bus.obj_we), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_busrq_n", 32'(bus.busrq_n), 32'd1);
    chk("t6_rst_cs", 32'(bus.dma_cs), 32'd0);
    chk("t6_rst_we", 32'(bus.obj_we), 32'd0);
    chk("t6_rst_busy", 32'(bus.busy), 32'd0);
    exp_q.delete();
    bus.VB = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    push_frame(int'(LEN));
    w0 = wr_cnt; d0 = done_cnt;
    vb_pulse();
    wait_idle("t6_idle", 200);
    settle();
    chk("t6_writes", wr_cnt - w0, int'(LEN));
    chk("t6_done", done_cnt - d0, 1);
    chk("t6_q_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
